// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction fields into 32-bit words and streams them to instruction memory.
// Optional feature: define ENC_ILLEGAL_CHECK_EN to reject illegal classes and raise a sticky error flag.
module instr_encoder #(
   parameter int MAX_WORDS = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  class_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [5:0]  funct_i,
   input  logic [15:0] imm_i,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_data_o,
   input  logic        imem_ready_i,
   output logic [8:0]  count_o,
   output logic        full_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [2:0] CLS_RTYPE = 3'b000;
   localparam logic [2:0] CLS_ADDI  = 3'b001;
   localparam logic [2:0] CLS_LW    = 3'b010;
   localparam logic [2:0] CLS_SW    = 3'b011;
   localparam logic [2:0] CLS_SLTI  = 3'b100;
   localparam logic [2:0] CLS_BEQ   = 3'b101;

   localparam logic [8:0] C_MAX_WORDS = 9'(MAX_WORDS);

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [8:0]  r_count;

   logic [31:0] w_enc_word;
   logic        w_req_ready;
   logic        w_accept;
   logic        w_do_write;
   logic        w_wr_done;
   logic [8:0]  w_count_inc;

   // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_enc_word = 32'h0000_0000;
      case (class_i)
         CLS_RTYPE: w_enc_word = {6'h00, rs_i, rt_i, rd_i, 5'b00000, funct_i};
         CLS_ADDI:  w_enc_word = {6'h08, rs_i, rt_i, imm_i};
         CLS_LW:    w_enc_word = {6'h23, rs_i, rt_i, imm_i};
         CLS_SW:    w_enc_word = {6'h2B, rs_i, rt_i, imm_i};
         CLS_SLTI:  w_enc_word = {6'h0A, rs_i, rt_i, imm_i};
         CLS_BEQ:   w_enc_word = {6'h04, rs_i, rt_i, imm_i};
         default:   w_enc_word = 32'h0000_0000;
      endcase
   end

   // start_i masks ready so a simultaneous request is never taken.
   assign w_req_ready = (r_state == ST_IDLE) && !start_i;
   assign w_accept    = req_valid_i && w_req_ready;
   assign w_wr_done   = (r_state == ST_WRITE) && imem_ready_i;
   assign w_count_inc = r_count + 9'd1;

`ifdef ENC_ILLEGAL_CHECK_EN
   logic w_illegal;
   logic w_set_err;
   logic r_err;

   assign w_illegal  = (class_i == 3'b110) || (class_i == 3'b111);
   assign w_do_write = w_accept && !w_illegal;
   assign w_set_err  = w_accept && w_illegal;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err <= 1'b0;
      end else if (start_i) begin
         r_err <= 1'b0;
      end else if (w_set_err) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   assign w_do_write = w_accept;
   assign err_o      = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (start_i) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_do_write) begin
                  w_state_next = ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (imem_ready_i) begin
                  w_state_next = (w_count_inc == C_MAX_WORDS) ? ST_FULL : ST_IDLE;
               end
            end
            ST_FULL: begin
               w_state_next = ST_FULL;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Address always points at the next word; data only changes when a new word is taken.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_addr  <= 32'h0000_0000;
         r_data  <= 32'h0000_0000;
         r_count <= 9'd0;
      end else if (start_i) begin
         r_addr  <= base_addr_i;
         r_count <= 9'd0;
      end else begin
         if (w_do_write) begin
            r_data <= w_enc_word;
         end
         if (w_wr_done) begin
            r_addr  <= r_addr + 32'd4;
            r_count <= w_count_inc;
         end
      end
   end

   assign req_ready_o = w_req_ready;
   assign imem_we_o   = (r_state == ST_WRITE);
   assign imem_addr_o = r_addr;
   assign imem_data_o = r_data;
   assign count_o     = r_count;
   assign full_o      = (r_state == ST_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-depth instance plus a MAX_WORDS=2 instance sharing stimulus.
`timescale 1ns/1ps
module tb_instr_encoder;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] base_addr_i = '0;
   logic        req_valid_i = 1'b0;
   logic [2:0]  class_i = '0;
   logic [4:0]  rs_i = '0;
   logic [4:0]  rt_i = '0;
   logic [4:0]  rd_i = '0;
   logic [5:0]  funct_i = '0;
   logic [15:0] imm_i = '0;
   logic        imem_ready_i = 1'b0;

   logic        req_ready_o, imem_we_o, full_o, err_o;
   logic [31:0] imem_addr_o, imem_data_o;
   logic [8:0]  count_o;

   logic        s_req_ready, s_we, s_full, s_err;
   logic [31:0] s_addr, s_data;
   logic [8:0]  s_count;

   int total = 0;
   int bad = 0;

   instr_encoder u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .class_i(class_i),
      .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i), .imm_i(imm_i),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
      .imem_ready_i(imem_ready_i), .count_o(count_o), .full_o(full_o), .err_o(err_o)
   );

   instr_encoder #(.MAX_WORDS(2)) u_small (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .req_valid_i(req_valid_i), .req_ready_o(s_req_ready), .class_i(class_i),
      .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i), .imm_i(imm_i),
      .imem_we_o(s_we), .imem_addr_o(s_addr), .imem_data_o(s_data),
      .imem_ready_i(imem_ready_i), .count_o(s_count), .full_o(s_full), .err_o(s_err)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_start(input logic [31:0] base);
      base_addr_i = base;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic set_req(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm);
      class_i = cls; rs_i = rs; rt_i = rt; rd_i = rd; funct_i = funct; imm_i = imm;
      req_valid_i = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_i = 1'b0;
      #1;
      total++; if (imem_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h want=0", imem_we_o); end
      total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%08h want=00000000", imem_addr_o); end
      total++; if (imem_data_o !== 32'h0) begin bad++; $display("FAIL rst_data got=%08h want=00000000", imem_data_o); end
      total++; if (count_o !== 9'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count_o); end
      total++; if (full_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL rst_flags got full=%0h err=%0h want 0 0", full_o, err_o); end
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h want=1", req_ready_o); end
      @(posedge clk_i);
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      tick();
   endtask

   task automatic test_addi();
      do_start(32'h0040_0000);
      total++; if (imem_addr_o !== 32'h0040_0000) begin bad++; $display("FAIL addi_base got=%08h want=00400000", imem_addr_o); end
      imem_ready_i = 1'b1;
      set_req(3'b001, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005);
      tick();
      req_valid_i = 1'b0;
      total++; if (imem_we_o !== 1'b1) begin bad++; $display("FAIL addi_we got=%0h want=1", imem_we_o); end
      total++; if (imem_data_o !== 32'h2022_0005) begin bad++; $display("FAIL addi_data got=%08h want=20220005", imem_data_o); end
      total++; if (imem_addr_o !== 32'h0040_0000) begin bad++; $display("FAIL addi_addr got=%08h want=00400000", imem_addr_o); end
      total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL addi_ready_in_write got=%0h want=0", req_ready_o); end
      tick();
      total++; if (imem_we_o !== 1'b0) begin bad++; $display("FAIL addi_we_after got=%0h want=0", imem_we_o); end
      total++; if (count_o !== 9'd1) begin bad++; $display("FAIL addi_count got=%0d want=1", count_o); end
      total++; if (imem_addr_o !== 32'h0040_0004) begin bad++; $display("FAIL addi_next_addr got=%08h want=00400004", imem_addr_o); end
   endtask

   task automatic test_rtype_stall();
      imem_ready_i = 1'b0;
      set_req(3'b000, 5'd1, 5'd2, 5'd3, 6'h20, 16'hBEEF);
      tick();
      req_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++; if (imem_we_o !== 1'b1 || imem_data_o !== 32'h0022_1820 || imem_addr_o !== 32'h0040_0004)
            begin bad++; $display("FAIL rtype_hold[%0d] got we=%0h data=%08h addr=%08h want 1 00221820 00400004", i, imem_we_o, imem_data_o, imem_addr_o); end
         total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rtype_ready[%0d] got=%0h want=0", i, req_ready_o); end
         if (i == 3) imem_ready_i = 1'b1;
         tick();
      end
      imem_ready_i = 1'b0;
      total++; if (imem_we_o !== 1'b0 || count_o !== 9'd2) begin bad++; $display("FAIL rtype_done got we=%0h count=%0d want 0 2", imem_we_o, count_o); end
      total++; if (imem_addr_o !== 32'h0040_0008) begin bad++; $display("FAIL rtype_next_addr got=%08h want=00400008", imem_addr_o); end
   endtask

   task automatic test_start_during_write();
      do_start(32'h0000_2000);
      imem_ready_i = 1'b0;
      set_req(3'b100, 5'd6, 5'd7, 5'd0, 6'h00, 16'hFFFF);
      tick();
      req_valid_i = 1'b0;
      total++; if (imem_we_o !== 1'b1 || imem_data_o !== 32'h28C7_FFFF) begin bad++; $display("FAIL slti_word got we=%0h data=%08h want 1 28C7FFFF", imem_we_o, imem_data_o); end
      imem_ready_i = 1'b1;
      base_addr_i = 32'h0000_3000;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      imem_ready_i = 1'b0;
      total++; if (imem_we_o !== 1'b0) begin bad++; $display("FAIL abort_we got=%0h want=0", imem_we_o); end
      total++; if (count_o !== 9'd0) begin bad++; $display("FAIL abort_count got=%0d want=0", count_o); end
      total++; if (imem_addr_o !== 32'h0000_3000) begin bad++; $display("FAIL abort_addr got=%08h want=00003000", imem_addr_o); end
   endtask

   task automatic test_full();
      do_start(32'h0000_1000);
      imem_ready_i = 1'b1;
      set_req(3'b010, 5'd4, 5'd5, 5'd0, 6'h00, 16'h0010);
      tick();
      total++; if (s_we !== 1'b1 || s_data !== 32'h8C85_0010 || s_addr !== 32'h0000_1000) begin bad++; $display("FAIL lw1 got we=%0h data=%08h addr=%08h want 1 8C850010 00001000", s_we, s_data, s_addr); end
      tick();
      total++; if (s_count !== 9'd1 || s_full !== 1'b0) begin bad++; $display("FAIL lw1_done got count=%0d full=%0h want 1 0", s_count, s_full); end
      tick();
      total++; if (s_we !== 1'b1 || s_addr !== 32'h0000_1004) begin bad++; $display("FAIL lw2 got we=%0h addr=%08h want 1 00001004", s_we, s_addr); end
      tick();
      total++; if (s_count !== 9'd2 || s_full !== 1'b1) begin bad++; $display("FAIL lw2_full got count=%0d full=%0h want 2 1", s_count, s_full); end
      tick();
      tick();
      total++; if (s_we !== 1'b0 || s_req_ready !== 1'b0 || s_count !== 9'd2 || s_full !== 1'b1)
         begin bad++; $display("FAIL lw3_held got we=%0h ready=%0h count=%0d full=%0h want 0 0 2 1", s_we, s_req_ready, s_count, s_full); end
      total++; if (s_addr !== 32'h0000_1008) begin bad++; $display("FAIL full_addr got=%08h want=00001008", s_addr); end
      start_i = 1'b1;
      tick();
      total++; if (s_count !== 9'd0 || s_full !== 1'b0 || s_addr !== 32'h0000_1000) begin bad++; $display("FAIL full_restart got count=%0d full=%0h addr=%08h want 0 0 00001000", s_count, s_full, s_addr); end
      total++; if (s_req_ready !== 1'b0) begin bad++; $display("FAIL start_masks_ready got=%0h want=0", s_req_ready); end
      tick();
      total++; if (s_we !== 1'b0 || s_count !== 9'd0) begin bad++; $display("FAIL start_priority got we=%0h count=%0d want 0 0", s_we, s_count); end
      start_i = 1'b0;
      tick();
      req_valid_i = 1'b0;
      total++; if (s_we !== 1'b1 || s_data !== 32'h8C85_0010) begin bad++; $display("FAIL lw3_accept got we=%0h data=%08h want 1 8C850010", s_we, s_data); end
      tick();
      imem_ready_i = 1'b0;
      total++; if (s_count !== 9'd1) begin bad++; $display("FAIL lw3_count got=%0d want=1", s_count); end
   endtask

   task automatic test_illegal();
      do_start(32'h0000_4000);
      imem_ready_i = 1'b1;
      set_req(3'b111, 5'd9, 5'd10, 5'd11, 6'h3F, 16'h1234);
      tick();
      req_valid_i = 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL ill_err got=%0h want=1", err_o); end
      total++; if (imem_we_o !== 1'b0 || req_ready_o !== 1'b1) begin bad++; $display("FAIL ill_nowrite got we=%0h ready=%0h want 0 1", imem_we_o, req_ready_o); end
      tick();
      total++; if (count_o !== 9'd0 || err_o !== 1'b1) begin bad++; $display("FAIL ill_sticky got count=%0d err=%0h want 0 1", count_o, err_o); end
      do_start(32'h0000_4000);
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL ill_clear got=%0h want=0", err_o); end
`else
      total++; if (imem_we_o !== 1'b1 || imem_data_o !== 32'h0000_0000) begin bad++; $display("FAIL ill_word got we=%0h data=%08h want 1 00000000", imem_we_o, imem_data_o); end
      tick();
      total++; if (count_o !== 9'd1 || imem_addr_o !== 32'h0000_4004) begin bad++; $display("FAIL ill_count got count=%0d addr=%08h want 1 00004004", count_o, imem_addr_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL ill_err_tied got=%0h want=0", err_o); end
`endif
      imem_ready_i = 1'b0;
   endtask

   task automatic test_wrap();
      do_start(32'hFFFF_FFFC);
      imem_ready_i = 1'b1;
      set_req(3'b011, 5'd8, 5'd9, 5'd0, 6'h00, 16'h0004);
      tick();
      total++; if (imem_we_o !== 1'b1 || imem_data_o !== 32'hAD09_0004 || imem_addr_o !== 32'hFFFF_FFFC)
         begin bad++; $display("FAIL sw1 got we=%0h data=%08h addr=%08h want 1 AD090004 FFFFFFFC", imem_we_o, imem_data_o, imem_addr_o); end
      tick();
      tick();
      req_valid_i = 1'b0;
      total++; if (imem_we_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin bad++; $display("FAIL sw2_wrap got we=%0h addr=%08h want 1 00000000", imem_we_o, imem_addr_o); end
      tick();
      imem_ready_i = 1'b0;
      total++; if (count_o !== 9'd2 || imem_addr_o !== 32'h0000_0004) begin bad++; $display("FAIL sw2_done got count=%0d addr=%08h want 2 00000004", count_o, imem_addr_o); end
   endtask

   task automatic test_reset_during_write();
      do_start(32'h0000_5000);
      imem_ready_i = 1'b0;
      set_req(3'b101, 5'd1, 5'd1, 5'd0, 6'h00, 16'h0008);
      tick();
      req_valid_i = 1'b0;
      total++; if (imem_we_o !== 1'b1 || imem_data_o !== 32'h1021_0008) begin bad++; $display("FAIL beq_word got we=%0h data=%08h want 1 10210008", imem_we_o, imem_data_o); end
      #2 rst_i = 1'b0;
      #1;
      total++; if (imem_we_o !== 1'b0 || imem_addr_o !== 32'h0 || imem_data_o !== 32'h0 || count_o !== 9'd0)
         begin bad++; $display("FAIL async_rst got we=%0h addr=%08h data=%08h count=%0d want 0 0 0 0", imem_we_o, imem_addr_o, imem_data_o, count_o); end
      #1 rst_i = 1'b1;
      imem_ready_i = 1'b1;
      tick();
      imem_ready_i = 1'b0;
      total++; if (imem_we_o !== 1'b0 || count_o !== 9'd0) begin bad++; $display("FAIL rst_discard got we=%0h count=%0d want 0 0", imem_we_o, count_o); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_rtype_stall();
      test_start_during_write();
      test_full();
      test_illegal();
      test_wrap();
      test_reset_during_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
